// File: rtl/bicubic_pkg.sv
// ============================================================================
// Module   : bicubic_pkg
// Brief    : Shared constants and types for the bicubic interpolator and the
//            pixel serializer that drains its 4-pixel output groups.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bicubic_pkg;

    localparam int PIX_W_DEF  = 8;
    localparam int GROUP_SIZE = 4;
    localparam int IDX_W      = $clog2(GROUP_SIZE);

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t IDX_LAST = idx_t'(GROUP_SIZE - 1);

endpackage : bicubic_pkg

`default_nettype wire

// File: rtl/pixel_serializer_if.sv
// ============================================================================
// Module   : pixel_serializer_if
// Brief    : Group-in / pixel-out handshake bundle of the pixel serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_serializer_if #(
    parameter int DEPTH = 4,
    parameter int PIX_W = bicubic_pkg::PIX_W_DEF
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_0;
    logic [PIX_W-1:0] in_1;
    logic [PIX_W-1:0] in_2;
    logic [PIX_W-1:0] in_3;
    logic [PIX_W-1:0] out_pix;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic [LVL_W-1:0] level;

    modport master (
        output in_valid, in_0, in_1, in_2, in_3, out_ready,
        input  in_ready, out_pix, out_valid, out_last, level
    );

    modport slave (
        input  in_valid, in_0, in_1, in_2, in_3, out_ready,
        output in_ready, out_pix, out_valid, out_last, level
    );

endinterface : pixel_serializer_if

`default_nettype wire

// File: rtl/pixel_serializer_group_fifo.sv
// ============================================================================
// Module   : group_fifo
// Brief    : DEPTH-entry synchronous FIFO of packed pixel groups with a
//            combinational head read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module group_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic                       i_pop,
    input  wire logic [DATA_W-1:0]          i_wdata,
    output logic      [DATA_W-1:0]          o_rdata,
    output logic                            o_full,
    output logic                            o_empty,
    output logic      [$clog2(DEPTH):0]     o_level
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam logic [LVL_W-1:0] C_FULL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_level == C_FULL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage is not reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : group_fifo

`default_nettype wire

// File: rtl/pixel_serializer.sv
// ============================================================================
// Module   : pixel_serializer
// Brief    : Buffers 4-pixel groups and emits them one pixel per transfer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_serializer
    import bicubic_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PIX_W = PIX_W_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pixel_serializer_if.slave bus
);
    localparam int GRP_W = GROUP_SIZE * PIX_W;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [GRP_W-1:0] w_wdata;
    logic [GRP_W-1:0] w_head;
    logic [PIX_W-1:0] w_pix [GROUP_SIZE];
    logic [LVL_W-1:0] w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_out_valid;
    logic             w_xfer;
    idx_t             r_idx;

    assign w_wdata     = {bus.in_3, bus.in_2, bus.in_1, bus.in_0};
    assign w_out_valid = !w_empty;
    assign w_push      = bus.in_valid && !w_full;
    assign w_xfer      = w_out_valid && bus.out_ready;
    assign w_pop       = w_xfer && (r_idx == IDX_LAST);

    group_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (GRP_W)
    ) u_group_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    generate
        for (genvar gi = 0; gi < GROUP_SIZE; gi++) begin : g_unpack
            assign w_pix[gi] = w_head[gi*PIX_W +: PIX_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_xfer) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Head is masked when empty so stale storage never reaches the sink.
    assign bus.out_pix   = w_out_valid ? w_pix[r_idx] : '0;
    assign bus.out_valid = w_out_valid;
    assign bus.out_last  = w_out_valid && (r_idx == IDX_LAST);
    assign bus.in_ready  = !w_full;
    assign bus.level     = w_level;

endmodule : pixel_serializer

`default_nettype wire

// File: tb/tb_pixel_serializer.sv
// ============================================================================
// Module   : tb_pixel_serializer
// Brief    : Directed self-checking bench for pixel_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_serializer;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    pixel_serializer_if #(.DEPTH(4), .PIX_W(8)) bus ();

    pixel_serializer #(.DEPTH(4), .PIX_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_group(input int base);
        bus.in_0 = 8'(base);
        bus.in_1 = 8'(base + 1);
        bus.in_2 = 8'(base + 2);
        bus.in_3 = 8'(base + 3);
    endtask

    task automatic set_group(input int a, input int b, input int c, input int d);
        bus.in_0 = 8'(a);
        bus.in_1 = 8'(b);
        bus.in_2 = 8'(c);
        bus.in_3 = 8'(d);
    endtask

    initial begin
        int vals [4];
        int p;
        int gi;
        int e;
        int cyc;
        logic acc;

        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_group(0, 0, 0, 0);
        step();
        step();

        // Reset state
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last",  bus.out_last,  0);
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_out_pix",   bus.out_pix,   0);
        chk("rst_level",     bus.level,     0);
        rst = 1'b0;

        // Single group, full-rate drain
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        set_group(1, 2, 3, 4);
        step();
        bus.in_valid = 1'b0;
        chk("single_level", bus.level, 1);
        for (int i = 0; i < 4; i++) begin
            chk("single_valid", bus.out_valid, 1);
            chk("single_pix",   bus.out_pix,   i + 1);
            chk("single_last",  bus.out_last,  (i == 3));
            step();
        end
        chk("single_empty", bus.out_valid, 0);

        // Fill with no drain: only four groups get in
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive_group(4 * k + 1);
            chk("fill_in_ready", bus.in_ready, (k < 4));
            step();
            chk("fill_level", bus.level, (k < 4) ? k + 1 : 4);
        end
        chk("fill_full_ready", bus.in_ready, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("fill_drain_pix", bus.out_pix, i + 1);
            step();
        end
        chk("fill_drain_empty", bus.out_valid, 0);

        // Backpressure: each pixel held while out_ready is low
        vals = '{10, 20, 30, 40};
        set_group(10, 20, 30, 40);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        p = 0;
        for (int c = 0; c < 8; c++) begin
            bus.out_ready = (c % 2 == 1);
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_pix",   bus.out_pix,   vals[p]);
            if (bus.out_ready) p++;
            step();
        end
        chk("bp_empty", bus.out_valid, 0);

        // Full FIFO with a pop on the same edge: push refused, then accepted
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            drive_group(100 + 4 * g);
            step();
        end
        chk("fp_level_full", bus.level, 4);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        step();
        chk("fp_last", bus.out_last, 1);
        bus.in_valid = 1'b1;
        drive_group(200);
        chk("fp_in_ready_full", bus.in_ready, 0);
        chk("fp_level_before",  bus.level,    4);
        step();
        chk("fp_level_after_pop", bus.level,    3);
        chk("fp_in_ready_after",  bus.in_ready, 1);
        bus.out_ready = 1'b0;
        step();
        chk("fp_level_refill", bus.level,    4);
        chk("fp_in_ready_ref", bus.in_ready, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("fp_drain_pix", bus.out_pix, (i < 12) ? 104 + i : 200 + (i - 12));
            step();
        end
        chk("fp_drain_empty", bus.out_valid, 0);

        // Reset in the middle of a group
        set_group(5, 6, 7, 8);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("mr_pix0", bus.out_pix, 5);
        step();
        chk("mr_pix1", bus.out_pix, 6);
        step();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        set_group(99, 98, 97, 96);
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("mr_valid", bus.out_valid, 0);
        chk("mr_level", bus.level,     0);
        chk("mr_pix",   bus.out_pix,   0);
        set_group(9, 10, 11, 12);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mr_new_pix",  bus.out_pix,  9 + i);
            chk("mr_new_last", bus.out_last, (i == 3));
            step();
        end
        chk("mr_new_empty", bus.out_valid, 0);

        // Streaming 20 groups with random sink stalls
        gi  = 0;
        e   = 1;
        cyc = 0;
        while (e <= 80 && cyc < 3000) begin
            bus.in_valid = (gi < 20);
            drive_group(4 * gi + 1);
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && bus.out_ready) begin
                chk("stream_pix",  bus.out_pix,  e);
                chk("stream_last", bus.out_last, (e % 4 == 0));
                e++;
            end
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) gi++;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("stream_count", e, 81);
        chk("stream_empty", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pixel_serializer

`default_nettype wire
